// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Byte-lane request/response bus between the MEM-stage access unit and a
// variable-latency data memory.
//
//   mem_req    master->slave  request, held until mem_ready
//   mem_we     master->slave  1 = write
//   mem_addr   master->slave  word address (ADDR_W bits)
//   mem_be     master->slave  byte enables, bit i = lane i (bits 8i+7:8i)
//   mem_wdata  master->slave  write data
//   mem_rdata  slave->master  read data, valid when mem_ready
//   mem_ready  slave->master  request completes this cycle
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store engine. Decodes the byte/half/word masks, checks
// alignment, drives a byte-lane request to a variable-latency memory, stalls
// the pipeline while the access is outstanding, extracts and extends load
// data, and aborts a request that waits longer than TIMEOUT cycles.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   MemtoRegM         load op present
//   MemWriteM         store op present (wins over MemtoRegM)
//   MemReadByteM      load mask  (0001 byte, 0011 half, else word)
//   MemWriteByteM     store mask (same encoding)
//   UnsignedM         1 = zero-extend loads, 0 = sign-extend
//   ALUOutM           byte address
//   WriteDataM        store data (low-order bytes used for byte/half)
//   StallM            freeze PC and IF/ID/EX/MEM registers
//   ReadDataM         registered, extended load result
//   ReadValidM        one-cycle pulse with ReadDataM
//   ErrM              sticky misalignment / timeout flag
//   mem               memory bus (master side)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [3:0]  MemReadByteM,
    input  logic [3:0]  MemWriteByteM,
    input  logic        UnsignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        ReadValidM,
    output logic        ErrM,
    mem_access_unit_if.master mem
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg;
    logic [7:0]        cnt_reg;
    logic              req_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic [1:0]        lane_reg;
    logic [31:0]       rdata_reg;
    logic              rvalid_reg;
    logic              err_reg;

    // ---------------- op decode ----------------
    logic       is_store;
    logic       op_present;
    logic [3:0] mask;
    logic [1:0] size_next;
    logic       aligned;
    logic [3:0] be_next;
    logic [3:0] byte_be;
    logic [31:0] wdata_next;

    assign is_store   = MemWriteM;
    assign op_present = MemWriteM | MemtoRegM;
    assign mask       = is_store ? MemWriteByteM : MemReadByteM;

    // One-hot lane enable for byte accesses.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_be
        assign byte_be[gi] = (ALUOutM[1:0] == 2'(gi));
    end

    always_comb begin
        size_next  = SZ_WORD;
        aligned    = (ALUOutM[1:0] == 2'b00);
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        case (mask)
            4'b0001: begin
                size_next  = SZ_BYTE;
                aligned    = 1'b1;
                be_next    = byte_be;
                wdata_next = {4{WriteDataM[7:0]}};
            end
            4'b0011: begin
                size_next  = SZ_HALF;
                aligned    = ~ALUOutM[0];
                be_next    = ALUOutM[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- load extraction ----------------
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
        assign rd_byte[gi] = mem.mem_rdata[8*gi +: 8];
    end

    always_comb begin
        sel_byte = rd_byte[lane_reg];
        sel_half = lane_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        load_ext = mem.mem_rdata;
        case (size_reg)
            SZ_BYTE: load_ext = {{24{~unsigned_reg & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_ext = {{16{~unsigned_reg & sel_half[15]}}, sel_half};
            default: ;
        endcase
    end

    // Stall is combinational in IDLE so the op is held on the very cycle it
    // is accepted; gating with rst_n drops it immediately during reset.
    assign StallM = rst_n & (((state_reg == IDLE) & op_present & aligned) |
                             (state_reg == BUSY));

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            size_reg     <= SZ_BYTE;
            unsigned_reg <= 1'b0;
            lane_reg     <= '0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            rvalid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op_present) begin
                        if (aligned) begin
                            addr_reg     <= ALUOutM[ADDR_W+1:2];
                            be_reg       <= be_next;
                            wdata_reg    <= wdata_next;
                            we_reg       <= is_store;
                            size_reg     <= size_next;
                            unsigned_reg <= UnsignedM;
                            lane_reg     <= ALUOutM[1:0];
                            req_reg      <= 1'b1;
                            cnt_reg      <= '0;
                            state_reg    <= BUSY;
                        end else begin
                            // Misaligned: no access, pipeline keeps moving.
                            err_reg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem.mem_ready) begin
                        req_reg <= 1'b0;
                        if (!we_reg) begin
                            rdata_reg  <= load_ext;
                            rvalid_reg <= 1'b1;
                        end
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        req_reg <= 1'b0;
                        err_reg <= 1'b1;
                        if (!we_reg) begin
                            rdata_reg  <= '0;
                            rvalid_reg <= 1'b1;
                        end
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                // The completed op is still on the inputs here; it must not
                // be re-issued, so DONE always returns to IDLE untouched.
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Upper address bits above the memory window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUOutM[31:ADDR_W+2];

    assign ReadDataM     = rdata_reg;
    assign ReadValidM    = rvalid_reg;
    assign ErrM          = err_reg;
    assign mem.mem_req   = req_reg;
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_be    = be_reg;
    assign mem.mem_wdata = wdata_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [3:0]  MemReadByteM = 4'b0;
    logic [3:0]  MemWriteByteM = 4'b0;
    logic        UnsignedM = 1'b0;
    logic [31:0] ALUOutM = 32'b0;
    logic [31:0] WriteDataM = 32'b0;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        ReadValidM;
    logic        ErrM;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_op for one operation.
    int          stall_cnt, req_cnt, valid_cnt;
    logic [31:0] data_obs, wdata_obs;
    logic [3:0]  be_obs;
    logic [9:0]  addr_obs;
    logic        we_obs;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(10)) mem_bus ();

    mem_access_unit #(.ADDR_W(10), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemtoRegM     (MemtoRegM),
        .MemWriteM     (MemWriteM),
        .MemReadByteM  (MemReadByteM),
        .MemWriteByteM (MemWriteByteM),
        .UnsignedM     (UnsignedM),
        .ALUOutM       (ALUOutM),
        .WriteDataM    (WriteDataM),
        .StallM        (StallM),
        .ReadDataM     (ReadDataM),
        .ReadValidM    (ReadValidM),
        .ErrM          (ErrM),
        .mem           (mem_bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        MemtoRegM = 1'b0; MemWriteM = 1'b0;
        MemReadByteM = 4'b0; MemWriteByteM = 4'b0;
        UnsignedM = 1'b0; ALUOutM = 32'b0; WriteDataM = 32'b0;
    endtask

    task automatic set_load(input logic [3:0] mask, input logic [31:0] addr, input logic uns);
        clear_op();
        MemtoRegM = 1'b1; MemReadByteM = mask; ALUOutM = addr; UnsignedM = uns;
    endtask

    task automatic set_store(input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] data);
        clear_op();
        MemWriteM = 1'b1; MemWriteByteM = mask; ALUOutM = addr; WriteDataM = data;
    endtask

    // Memory responder + pipeline model: ready arrives in BUSY cycle 'waits'
    // (if respond), op is removed after the first edge where StallM was low.
    task automatic run_op(input int waits, input logic respond, input logic [31:0] rdata);
        logic consumed;
        logic stall_now;
        stall_cnt = 0; req_cnt = 0; valid_cnt = 0;
        data_obs = 32'b0; wdata_obs = 32'b0; be_obs = 4'b0; addr_obs = 10'b0; we_obs = 1'b0;
        consumed = 1'b0;
        mem_bus.mem_rdata = rdata;
        for (int c = 0; c < 12; c++) begin
            if (mem_bus.mem_req) begin
                if (req_cnt == 0) begin
                    be_obs = mem_bus.mem_be; addr_obs = mem_bus.mem_addr;
                    wdata_obs = mem_bus.mem_wdata; we_obs = mem_bus.mem_we;
                end
                mem_bus.mem_ready = respond && (req_cnt == waits);
                req_cnt++;
            end else begin
                mem_bus.mem_ready = 1'b0;
            end
            #1;
            if (StallM) stall_cnt++;
            if (ReadValidM) begin
                valid_cnt++;
                data_obs = ReadDataM;
            end
            stall_now = StallM;
            step();
            if (!consumed && !stall_now) begin
                consumed = 1'b1;
                clear_op();
            end
        end
        mem_bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'b0;
        set_load(4'b1111, 32'h0, 1'b0);   // aligned op present during reset
        step(); step();
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", StallM); end
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_bus.mem_req); end
        checks++; if (ReadValidM !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ReadValidM); end
        checks++; if (ErrM !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", ErrM); end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", ReadDataM); end
        checks++; if (mem_bus.mem_be !== 4'b0) begin errors++; $display("FAIL rst_be: got %b expected 0000", mem_bus.mem_be); end
        clear_op();
        rst_n = 1'b1;
        step();
        $display("reset: checked idle outputs");
    endtask

    task automatic test_load_byte();
        set_load(4'b0001, 32'h0000_0006, 1'b0);
        run_op(0, 1'b1, 32'h12F0_5634);
        checks++; if (be_obs !== 4'b0100) begin errors++; $display("FAIL lb_be: got %b expected 0100", be_obs); end
        checks++; if (addr_obs !== 10'd1) begin errors++; $display("FAIL lb_addr: got %0d expected 1", addr_obs); end
        checks++; if (we_obs !== 1'b0) begin errors++; $display("FAIL lb_we: got %b expected 0", we_obs); end
        checks++; if (data_obs !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_data: got %h expected fffffff0", data_obs); end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL lb_valid: got %0d pulses expected 1", valid_cnt); end
        checks++; if (stall_cnt != 2) begin errors++; $display("FAIL lb_stall: got %0d cycles expected 2", stall_cnt); end
        checks++; if (req_cnt != 1) begin errors++; $display("FAIL lb_req: got %0d cycles expected 1", req_cnt); end
        $display("LB  addr=0x6 data=%h stall=%0d", data_obs, stall_cnt);
    endtask

    task automatic test_load_half_wait();
        set_load(4'b0011, 32'h0000_0002, 1'b1);
        run_op(3, 1'b1, 32'h8001_7FFF);
        checks++; if (be_obs !== 4'b1100) begin errors++; $display("FAIL lhu_be: got %b expected 1100", be_obs); end
        checks++; if (data_obs !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h expected 00008001", data_obs); end
        checks++; if (stall_cnt != 5) begin errors++; $display("FAIL lhu_stall: got %0d expected 5", stall_cnt); end
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL lhu_req: got %0d expected 4", req_cnt); end
        $display("LHU addr=0x2 data=%h stall=%0d req=%0d", data_obs, stall_cnt, req_cnt);

        set_load(4'b0011, 32'h0000_0002, 1'b0);
        run_op(1, 1'b1, 32'h8001_7FFF);
        checks++; if (data_obs !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", data_obs); end
        checks++; if (stall_cnt != 3) begin errors++; $display("FAIL lh_stall: got %0d expected 3", stall_cnt); end
        $display("LH  addr=0x2 data=%h stall=%0d", data_obs, stall_cnt);

        set_load(4'b1111, 32'h0000_0004, 1'b0);
        run_op(0, 1'b1, 32'h8001_7FFF);
        checks++; if (data_obs !== 32'h8001_7FFF) begin errors++; $display("FAIL lw_data: got %h expected 80017fff", data_obs); end
        checks++; if (be_obs !== 4'b1111 || addr_obs !== 10'd1) begin errors++; $display("FAIL lw_lane: got be=%b addr=%0d expected be=1111 addr=1", be_obs, addr_obs); end
        $display("LW  addr=0x4 data=%h", data_obs);
    endtask

    task automatic test_store();
        set_store(4'b0001, 32'h0000_0003, 32'hAABB_CCDD);
        run_op(0, 1'b1, 32'h0);
        checks++; if (we_obs !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", we_obs); end
        checks++; if (be_obs !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", be_obs); end
        checks++; if (wdata_obs !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata: got %h expected dddddddd", wdata_obs); end
        checks++; if (addr_obs !== 10'd0) begin errors++; $display("FAIL sb_addr: got %0d expected 0", addr_obs); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL sb_valid: got %0d pulses expected 0", valid_cnt); end
        checks++; if (ReadDataM !== 32'h8001_7FFF) begin errors++; $display("FAIL sb_hold: got %h expected 80017fff", ReadDataM); end
        $display("SB  addr=0x3 be=%b wdata=%h", be_obs, wdata_obs);

        set_store(4'b0011, 32'h0000_0002, 32'h1234_ABCD);
        run_op(2, 1'b1, 32'h0);
        checks++; if (be_obs !== 4'b1100 || wdata_obs !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_lane: got be=%b wdata=%h expected be=1100 wdata=abcdabcd", be_obs, wdata_obs); end
        checks++; if (stall_cnt != 4) begin errors++; $display("FAIL sh_stall: got %0d expected 4", stall_cnt); end
        $display("SH  addr=0x2 be=%b wdata=%h", be_obs, wdata_obs);

        set_store(4'b1111, 32'h0000_0010, 32'hCAFE_BABE);
        run_op(0, 1'b1, 32'h0);
        checks++; if (be_obs !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", be_obs); end
        checks++; if (addr_obs !== 10'd4) begin errors++; $display("FAIL sw_addr: got %0d expected 4", addr_obs); end
        checks++; if (wdata_obs !== 32'hCAFE_BABE) begin errors++; $display("FAIL sw_wdata: got %h expected cafebabe", wdata_obs); end
        $display("SW  addr=0x10 be=%b addr=%0d", be_obs, addr_obs);
    endtask

    task automatic test_write_priority();
        clear_op();
        MemtoRegM = 1'b1; MemWriteM = 1'b1;
        MemReadByteM = 4'b0001; MemWriteByteM = 4'b1111;
        ALUOutM = 32'h0000_0008; WriteDataM = 32'h0BAD_F00D;
        run_op(0, 1'b1, 32'h0);
        checks++; if (we_obs !== 1'b1) begin errors++; $display("FAIL prio_we: got %b expected 1", we_obs); end
        checks++; if (be_obs !== 4'b1111 || wdata_obs !== 32'h0BAD_F00D) begin errors++; $display("FAIL prio_lane: got be=%b wdata=%h expected be=1111 wdata=0badf00d", be_obs, wdata_obs); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL prio_valid: got %0d pulses expected 0", valid_cnt); end
        checks++; if (ErrM !== 1'b0) begin errors++; $display("FAIL prio_err: got %b expected 0", ErrM); end
        $display("LD+ST addr=0x8 treated as store we=%b be=%b", we_obs, be_obs);
    endtask

    task automatic test_timeout();
        set_load(4'b1111, 32'h0000_0020, 1'b0);
        run_op(0, 1'b0, 32'h5555_5555);
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL to_req: got %0d cycles expected 4", req_cnt); end
        checks++; if (stall_cnt != 5) begin errors++; $display("FAIL to_stall: got %0d expected 5", stall_cnt); end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL to_valid: got %0d pulses expected 1", valid_cnt); end
        checks++; if (data_obs !== 32'h0) begin errors++; $display("FAIL to_data: got %h expected 0", data_obs); end
        checks++; if (ErrM !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", ErrM); end
        $display("LW timeout req=%0d err=%b", req_cnt, ErrM);
        // Back in IDLE: a fresh op is accepted and completes.
        set_load(4'b0001, 32'h0000_0001, 1'b1);
        run_op(0, 1'b1, 32'h0000_9900);
        checks++; if (data_obs !== 32'h0000_0099 || valid_cnt != 1) begin errors++; $display("FAIL to_recover: got data=%h valid=%0d expected data=00000099 valid=1", data_obs, valid_cnt); end
        $display("LBU after timeout data=%h", data_obs);
    endtask

    task automatic test_reset_busy();
        set_load(4'b1111, 32'h0000_0004, 1'b0);
        mem_bus.mem_ready = 1'b0;
        step();
        checks++; if (mem_bus.mem_req !== 1'b1 || StallM !== 1'b1) begin errors++; $display("FAIL rb_busy: got req=%b stall=%b expected 1 1", mem_bus.mem_req, StallM); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL rb_req: got %b expected 0", mem_bus.mem_req); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rb_stall: got %b expected 0", StallM); end
        checks++; if (ErrM !== 1'b0) begin errors++; $display("FAIL rb_err: got %b expected 0", ErrM); end
        step();
        clear_op();
        rst_n = 1'b1;
        step(); step(); step();
        checks++; if (mem_bus.mem_req !== 1'b0 || ReadValidM !== 1'b0) begin errors++; $display("FAIL rb_resume: got req=%b valid=%b expected 0 0", mem_bus.mem_req, ReadValidM); end
        $display("reset during BUSY: req=%b stall=%b", mem_bus.mem_req, StallM);
    endtask

    task automatic test_misaligned();
        set_load(4'b1111, 32'h0000_0002, 1'b0);
        run_op(0, 1'b1, 32'h0);
        checks++; if (req_cnt != 0 || stall_cnt != 0) begin errors++; $display("FAIL mis_lw: got req=%0d stall=%0d expected 0 0", req_cnt, stall_cnt); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL mis_valid: got %0d expected 0", valid_cnt); end
        checks++; if (ErrM !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", ErrM); end
        $display("LW misaligned addr=0x2 err=%b", ErrM);

        set_load(4'b0001, 32'h0000_0000, 1'b0);
        run_op(0, 1'b1, 32'h0000_00A5);
        checks++; if (data_obs !== 32'hFFFF_FFA5 || valid_cnt != 1) begin errors++; $display("FAIL mis_good: got data=%h valid=%0d expected ffffffa5 1", data_obs, valid_cnt); end
        checks++; if (ErrM !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", ErrM); end
        $display("LB after error data=%h err=%b", data_obs, ErrM);

        set_store(4'b0011, 32'h0000_0001, 32'h1111_2222);
        run_op(0, 1'b1, 32'h0);
        checks++; if (req_cnt != 0 || stall_cnt != 0) begin errors++; $display("FAIL mis_sh: got req=%0d stall=%0d expected 0 0", req_cnt, stall_cnt); end
        $display("SH misaligned addr=0x1 err=%b", ErrM);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_wait();
        test_store();
        test_write_priority();
        test_timeout();
        test_reset_busy();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the decoder's MemReadByte/MemWriteByte masks; turns load/store ops into byte-lane requests to a variable-latency data memory.
- Responsible for lane selection, load extraction and sign/zero extension, store data replication, pipeline stall generation and a bounded-wait timeout.
- Sits between the EX/MEM register and the data memory; its registered load data feeds the MEM/WB register.

Parameters:
- ADDR_W, 10, word-address width driven to the memory (byte address bits [ADDR_W+1:2]).
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready before abort (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemtoRegM  in  1  load op present.
- MemWriteM  in  1  store op present.
- MemReadByteM  in  4  load mask: 0001 byte, 0011 half, 1111 word.
- MemWriteByteM  in  4  store mask, same encoding.
- UnsignedM  in  1  1 = zero-extend loads (LBU/LHU/LWU), 0 = sign-extend.
- ALUOutM  in  32  byte address.
- WriteDataM  in  32  store data (low-order bytes used for byte/half).
- StallM  out  1  freeze PC and IF/ID/EX/MEM registers.
- ReadDataM  out  32  registered, extended load result.
- ReadValidM  out  1  one-cycle pulse with ReadDataM.
- ErrM  out  1  sticky: misalignment or timeout.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid when mem_ready.
- mem_ready  in  1  request completes this cycle.

Behaviour:
- Reset (async, while rst_n=0): state IDLE; StallM, ReadValidM, ErrM, mem_req, mem_we = 0; ReadDataM, mem_addr, mem_be, mem_wdata, timeout counter = 0. An in-flight request is dropped immediately. No resumption after reset release.
- Op decode: MemWriteM=1 means store, even when MemtoRegM=1 (write priority). The mask comes from MemWriteByteM for stores and MemReadByteM for loads. Any mask other than 0001/0011 is treated as word.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00.
- Misaligned op:
  - No memory access, StallM stays 0.
  - ErrM is set on the next edge and held until reset.
  - Loads of this kind give no ReadValidM.
- Lanes: byte uses lane = addr[1:0], be = 0001<<lane. Half uses be = 0011 (addr[1]=0) or 1100 (addr[1]=1). Word uses be = 1111.
- Store data: byte = {4{WriteDataM[7:0]}}, half = {2{WriteDataM[15:0]}}, word = WriteDataM.
- FSM IDLE / BUSY / DONE:
  - IDLE, aligned op present:
    - StallM=1 combinationally.
    - On the edge: capture mem_addr, mem_be, mem_wdata, mem_we, mask, UnsignedM and addr[1:0]; set mem_req=1; clear counter; go BUSY.
  - BUSY, mem_ready=1:
    - On the edge: mem_req=0.
    - For a load, ReadDataM = extracted lane, extended to 32 bits (sign bit = MSB of selected byte/half; word is unchanged), and ReadValidM=1 in DONE.
    - Go DONE.
  - BUSY, mem_ready=0: StallM=1 and counter increments. When the counter reaches TIMEOUT-1 without ready: mem_req=0, ErrM=1, ReadDataM=0, ReadValidM=1 if load, go DONE.
  - DONE:
    - StallM=0, so the pipeline advances at the end of this cycle.
    - No new op is accepted; the still-present op is not re-issued.
    - ReadValidM deasserts; go IDLE.
- Latency: load with a 0-wait memory (ready in the first BUSY cycle) stalls exactly 2 cycles (IDLE-accept, BUSY); data in DONE. Each wait state adds 1 stall cycle.
- Outputs mem_addr/be/wdata/we are stable while mem_req=1. ReadDataM holds its value until the next load completes.
- mem_ready outside BUSY is ignored.

Test Plan:
- LB addr 0x0000_0006, mem_rdata 0x12F0_5634, UnsignedM=0, ready 1st BUSY cycle -> mem_be=0100, mem_addr=1, ReadDataM=0xFFFF_FFF0, ReadValidM pulse in DONE, StallM high exactly 2 cycles.
- LHU addr 0x0000_0002, mem_rdata 0x8001_7FFF, UnsignedM=1, 3 wait states -> mem_be=1100, ReadDataM=0x0000_8001, StallM high 5 cycles, mem_req held 4 cycles.
- SB addr 0x0000_0003, WriteDataM 0xAABB_CCDD -> mem_we=1, mem_be=1000, mem_wdata=0xDDDD_DDDD, no ReadValidM. SW to 0x0000_0010 -> be=1111, mem_addr=4.
- LW addr 0x0000_0002 -> no mem_req, StallM=0, ErrM=1 next edge and stays 1 across later good ops. SH addr 0x1 -> same.
- LW with mem_ready never asserted, TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, ErrM=1, ReadDataM=0, ReadValidM pulse, return to IDLE.
- rst_n low during BUSY -> mem_req, StallM = 0 asynchronously, state IDLE. MemtoRegM=MemWriteM=1 -> treated as store.
